// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction classes,
// ALU operation codes, datapath select codes and MIPS-style opcode/funct values.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CL_ILL,
    CL_RALU,
    CL_JR,
    CL_IMM,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_BNE,
    CL_J,
    CL_JAL
  } inst_class_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;

  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_R31   = 2'd2;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// Combinational instruction decode: opcode/funct to instruction class, alu_op and legality.
// SLT/SLTI are legal only when MULTICYCLE_CONTROL_SLT_EN is defined.
module mc_alu_decode
  import multicycle_control_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  output logic [OP_W-1:0] alu_op,
  output logic            legal,
  output inst_class_t     cls,
  output logic            shift,
  output logic            srl
);

  always_comb begin
    alu_op = '0;
    cls    = CL_ILL;
    shift  = 1'b0;
    srl    = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD: begin cls = CL_RALU; alu_op = OP_W'(ALU_ADD); end
          FN_SUB: begin cls = CL_RALU; alu_op = OP_W'(ALU_SUB); end
          FN_AND: begin cls = CL_RALU; alu_op = OP_W'(ALU_AND); end
          FN_OR:  begin cls = CL_RALU; alu_op = OP_W'(ALU_OR);  end
          FN_XOR: begin cls = CL_RALU; alu_op = OP_W'(ALU_XOR); end
          FN_SLL: begin cls = CL_RALU; shift = 1'b1; end
          FN_SRL: begin cls = CL_RALU; shift = 1'b1; srl = 1'b1; end
          FN_JR:  cls = CL_JR;
`ifdef MULTICYCLE_CONTROL_SLT_EN
          FN_SLT: begin cls = CL_RALU; alu_op = OP_W'(ALU_SLT); end
`endif
          default: cls = CL_ILL;
        endcase
      end
      OPC_ADDI: begin cls = CL_IMM; alu_op = OP_W'(ALU_ADD); end
      OPC_ANDI: begin cls = CL_IMM; alu_op = OP_W'(ALU_AND); end
      OPC_ORI:  begin cls = CL_IMM; alu_op = OP_W'(ALU_OR);  end
      OPC_XORI: begin cls = CL_IMM; alu_op = OP_W'(ALU_XOR); end
`ifdef MULTICYCLE_CONTROL_SLT_EN
      OPC_SLTI: begin cls = CL_IMM; alu_op = OP_W'(ALU_SLT); end
`endif
      OPC_LW:   begin cls = CL_LW;  alu_op = OP_W'(ALU_ADD); end
      OPC_SW:   begin cls = CL_SW;  alu_op = OP_W'(ALU_ADD); end
      OPC_BEQ:  begin cls = CL_BEQ; alu_op = OP_W'(ALU_SUB); end
      OPC_BNE:  begin cls = CL_BNE; alu_op = OP_W'(ALU_SUB); end
      OPC_J:    cls = CL_J;
      OPC_JAL:  cls = CL_JAL;
      default:  cls = CL_ILL;
    endcase
    legal = (cls != CL_ILL);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory wait timeout.
// Optional SLT/SLTI support: define MULTICYCLE_CONTROL_SLT_EN.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            ir_write,
  output logic            pc_write,
  output logic            mem_req,
  output logic            mem_we,
  output logic            iord,
  output logic            reg_write,
  output logic            shift,
  output logic            srl,
  output logic [1:0]      pc_src,
  output logic [1:0]      wb_sel,
  output logic [1:0]      reg_dst,
  output logic            alu_src_b,
  output logic [OP_W-1:0] alu_op,
  output logic            illegal,
  output logic            mem_err,
  output logic [2:0]      state
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            lw_q, sw_q, rt_q;
  logic            timeout_hit;

  logic [OP_W-1:0] dec_alu_op;
  logic            dec_legal, dec_shift, dec_srl;
  inst_class_t     dec_cls;

  mc_alu_decode #(.OP_W(OP_W)) u_dec (
    .opcode (opcode),
    .funct  (funct),
    .alu_op (dec_alu_op),
    .legal  (dec_legal),
    .cls    (dec_cls),
    .shift  (dec_shift),
    .srl    (dec_srl)
  );

  // Instruction flavour is captured in EXEC so MEM and WB do not depend on opcode/funct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      lw_q    <= 1'b0;
      sw_q    <= 1'b0;
      rt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_EXEC) begin
        lw_q <= (dec_cls == CL_LW);
        sw_q <= (dec_cls == CL_SW);
        rt_q <= (dec_cls == CL_RALU);
      end
    end
  end

  // A ready response in the timeout cycle takes priority, so the timeout requires !mem_ready.
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_VAL) && !mem_ready &&
                       ((state_q == S_FETCH) || (state_q == S_MEM));

  always_comb begin
    state_d   = state_q;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    reg_write = 1'b0;
    shift     = 1'b0;
    srl       = 1'b0;
    pc_src    = PC_PLUS4;
    wb_sel    = WB_ALU;
    reg_dst   = RD_RT;
    alu_src_b = 1'b0;
    alu_op    = '0;
    illegal   = 1'b0;
    mem_err   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          mem_req  = 1'b1;
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          mem_err  = 1'b1;
          state_d  = S_FETCH;
        end else begin
          mem_req  = 1'b1;
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op  = dec_alu_op;
        state_d = S_FETCH;
        case (dec_cls)
          CL_RALU: begin
            shift   = dec_shift;
            srl     = dec_srl;
            state_d = S_WB;
          end
          CL_JR: begin
            pc_write = 1'b1;
            pc_src   = PC_REG;
          end
          CL_IMM: begin
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          CL_LW, CL_SW: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          CL_BEQ: begin
            pc_write = zero;
            pc_src   = zero ? PC_BRANCH : PC_PLUS4;
          end
          CL_BNE: begin
            pc_write = !zero;
            pc_src   = zero ? PC_PLUS4 : PC_BRANCH;
          end
          CL_J: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end
          CL_JAL: begin
            pc_write  = 1'b1;
            pc_src    = PC_JUMP;
            reg_write = 1'b1;
            reg_dst   = RD_R31;
            wb_sel    = WB_PC4;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = sw_q;
          state_d = sw_q ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = sw_q;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = lw_q ? WB_MEM : WB_ALU;
        reg_dst   = rt_q ? RD_RD : RD_RT;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Wait counter restarts on every entry to FETCH/MEM and after each timeout.
  always_comb begin
    cnt_d = cnt_q;
    if (((state_q != S_FETCH) && (state_q != S_MEM)) || (state_d != state_q) || timeout_hit)
      cnt_d = '0;
    else if (!mem_ready)
      cnt_d = cnt_q + CNT_W'(1);
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected cycle trace.
module tb_multicycle_control;

  localparam int TB_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       ir_write, pc_write, mem_req, mem_we, iord, reg_write, shift, srl;
  logic [1:0] pc_src, wb_sel, reg_dst;
  logic       alu_src_b;
  logic [3:0] alu_op;
  logic       illegal, mem_err;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int seg = 0;

  always #5 clk = ~clk;

  multicycle_control #(.OP_W(4), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .reg_write(reg_write),
    .shift(shift), .srl(srl), .pc_src(pc_src), .wb_sel(wb_sel),
    .reg_dst(reg_dst), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal(illegal), .mem_err(mem_err), .state(state)
  );

  typedef struct packed {
    logic       ir_write, pc_write, mem_req, mem_we, iord, reg_write, shift, srl;
    logic [1:0] pc_src, wb_sel, reg_dst;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic       illegal, mem_err;
    logic [2:0] state;
  } out_t;

  typedef struct {
    logic       rdy;
    logic       z;
    logic [5:0] op;
    logic [5:0] fn;
    out_t       exp;
  } cyc_t;

  cyc_t prog[$];

  function automatic out_t sample();
    out_t a;
    a = '0;
    a.ir_write = ir_write; a.pc_write = pc_write; a.mem_req = mem_req;
    a.mem_we = mem_we; a.iord = iord; a.reg_write = reg_write;
    a.shift = shift; a.srl = srl; a.pc_src = pc_src; a.wb_sel = wb_sel;
    a.reg_dst = reg_dst; a.alu_src_b = alu_src_b; a.alu_op = alu_op;
    a.illegal = illegal; a.mem_err = mem_err; a.state = state;
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // EXEC-cycle behaviour straight from the instruction set rules.
  // nxt: 0 = back to fetch, 3 = memory access, 4 = write-back.
  function automatic void spec_exec(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                    output out_t e, output int nxt, output logic legal,
                                    output logic rt, output logic lw, output logic sw);
    e = '0; e.state = 3'd2; nxt = 0; legal = 1'b1; rt = 1'b0; lw = 1'b0; sw = 1'b0;
    if (op == 6'b000000) begin
      rt = 1'b1; nxt = 4;
      if      (fn == 6'b100000) e.alu_op = 4'd0;
      else if (fn == 6'b100010) e.alu_op = 4'd1;
      else if (fn == 6'b100100) e.alu_op = 4'd2;
      else if (fn == 6'b100101) e.alu_op = 4'd3;
      else if (fn == 6'b100110) e.alu_op = 4'd4;
      else if (fn == 6'b000000) e.shift = 1'b1;
      else if (fn == 6'b000010) begin e.shift = 1'b1; e.srl = 1'b1; end
      else if (fn == 6'b001000) begin e.pc_write = 1'b1; e.pc_src = 2'd3; nxt = 0; end
`ifdef MULTICYCLE_CONTROL_SLT_EN
      else if (fn == 6'b101010) e.alu_op = 4'd5;
`endif
      else legal = 1'b0;
    end
    else if (op == 6'b001000) begin e.alu_src_b = 1'b1; e.alu_op = 4'd0; nxt = 4; end
    else if (op == 6'b001100) begin e.alu_src_b = 1'b1; e.alu_op = 4'd2; nxt = 4; end
    else if (op == 6'b001101) begin e.alu_src_b = 1'b1; e.alu_op = 4'd3; nxt = 4; end
    else if (op == 6'b001110) begin e.alu_src_b = 1'b1; e.alu_op = 4'd4; nxt = 4; end
`ifdef MULTICYCLE_CONTROL_SLT_EN
    else if (op == 6'b001010) begin e.alu_src_b = 1'b1; e.alu_op = 4'd5; nxt = 4; end
`endif
    else if (op == 6'b100011) begin e.alu_src_b = 1'b1; lw = 1'b1; nxt = 3; end
    else if (op == 6'b101011) begin e.alu_src_b = 1'b1; sw = 1'b1; nxt = 3; end
    else if (op == 6'b000100) begin
      e.alu_op = 4'd1;
      if (z) begin e.pc_write = 1'b1; e.pc_src = 2'd1; end
    end
    else if (op == 6'b000101) begin
      e.alu_op = 4'd1;
      if (!z) begin e.pc_write = 1'b1; e.pc_src = 2'd1; end
    end
    else if (op == 6'b000010) begin e.pc_write = 1'b1; e.pc_src = 2'd2; end
    else if (op == 6'b000011) begin
      e.pc_write = 1'b1; e.pc_src = 2'd2; e.reg_write = 1'b1; e.reg_dst = 2'd2; e.wb_sel = 2'd2;
    end
    else legal = 1'b0;
  endfunction

  task automatic push(input logic r, input logic z, input logic [5:0] op, input logic [5:0] fn,
                      input out_t e);
    cyc_t c;
    c.rdy = r; c.z = z; c.op = op; c.fn = fn; c.exp = e;
    prog.push_back(c);
  endtask

  // Expand one instruction into its cycle trace: fw low cycles before fetch completes,
  // mw low cycles before the data access completes, idle = mem_ready outside FETCH/MEM.
  task automatic gen(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic idle,
                     input int fw, input int mw);
    out_t e, ex;
    int   nxt, lows;
    logic legal, rt, lw, sw;
    lows = 0;
    for (int i = 0; i < fw; i++) begin
      e = '0;
      if (lows == TB_TIMEOUT) begin e.mem_err = 1'b1; lows = 0; end
      else begin e.mem_req = 1'b1; lows++; end
      push(1'b0, z, op, fn, e);
    end
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(1'b1, z, op, fn, e);
    spec_exec(op, fn, z, ex, nxt, legal, rt, lw, sw);
    e = '0; e.state = 3'd1; e.illegal = !legal;
    push(idle, z, op, fn, e);
    if (!legal) return;
    push(idle, z, op, fn, ex);
    if (nxt == 3) begin
      lows = 0;
      for (int i = 0; i < mw; i++) begin
        e = '0; e.state = 3'd3;
        if (lows == TB_TIMEOUT) begin
          e.mem_err = 1'b1;
          push(1'b0, z, op, fn, e);
          return;
        end
        e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = sw; lows++;
        push(1'b0, z, op, fn, e);
      end
      e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = sw;
      push(1'b1, z, op, fn, e);
      if (sw) return;
    end
    if (nxt == 4 || lw) begin
      e = '0; e.state = 3'd4; e.reg_write = 1'b1;
      e.wb_sel = lw ? 2'd1 : 2'd0;
      e.reg_dst = rt ? 2'd1 : 2'd0;
      push(idle, z, op, fn, e);
    end
  endtask

  // Drive each cycle's inputs after the falling edge and compare the full output vector.
  task automatic run_prog(output int err_idx);
    out_t a;
    err_idx = -1;
    for (int i = 0; i < prog.size(); i++) begin
      mem_ready = prog[i].rdy; zero = prog[i].z; opcode = prog[i].op; funct = prog[i].fn;
      #1;
      a = sample();
      if (a.mem_err && err_idx < 0) err_idx = i;
      chk($sformatf("seg%0d_cyc%0d", seg, i), 32'(a), 32'(prog[i].exp));
      @(negedge clk);
    end
    prog.delete();
    seg++;
  endtask

  task automatic do_reset();
    out_t idle_v;
    idle_v = '0; idle_v.mem_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    #2;
    chk("reset_state", 32'(state), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_outputs", 32'(sample()), 32'(idle_v));
  endtask

  localparam int NT = 22;
  logic [5:0] t_op [0:NT-1] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010,
                                6'b000010, 6'b000011, 6'b000100, 6'b000100, 6'b101011,
                                6'b100011, 6'b111111};
  logic [5:0] t_fn [0:NT-1] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                6'b000000, 6'b000010, 6'b001000, 6'b101010, 6'b000001,
                                6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                6'b000000, 6'b000000};
  logic       t_z  [0:NT-1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                1'b1, 1'b0};

  initial begin
    int ei, we_seen;
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    do_reset();

    // ADD with mem_ready always high: states 0,1,2,4.
    gen(6'b000000, 6'b100000, 1'b0, 1'b1, 0, 0);
    chk("pin_add_len", 32'(prog.size()), 32'd4);
    chk("pin_add_states", 32'({prog[0].exp.state, prog[1].exp.state,
                               prog[2].exp.state, prog[3].exp.state}), 32'(12'o0124));
    chk("pin_add_wb", 32'({prog[3].exp.reg_write, prog[3].exp.reg_dst}), 32'(3'b101));
    run_prog(ei);

    // LW with three wait cycles in MEM: eight cycles total, last one loads from memory.
    gen(6'b100011, 6'b000000, 1'b0, 1'b0, 0, 3);
    chk("pin_lw_len", 32'(prog.size()), 32'd8);
    chk("pin_lw_wbsel", 32'(prog[7].exp.wb_sel), 32'd1);
    run_prog(ei);

    gen(6'b000101, 6'b000000, 1'b0, 1'b0, 0, 0);
    chk("pin_bne_taken", 32'({prog[2].exp.pc_write, prog[2].exp.pc_src}), 32'(3'b101));
    run_prog(ei);
    gen(6'b000101, 6'b000000, 1'b1, 1'b0, 0, 0);
    chk("pin_bne_not_taken", 32'(prog[2].exp.pc_write), 32'd0);
    run_prog(ei);

    // Fetch timeout on the fifth low cycle, then a ready arriving exactly at the limit.
    gen(6'b000000, 6'b100000, 1'b0, 1'b0, 5, 0);
    run_prog(ei);
    chk("fetch_timeout_cycle", 32'(ei), 32'd4);
    gen(6'b000000, 6'b100000, 1'b0, 1'b0, 4, 0);
    run_prog(ei);
    chk("ready_wins_no_err", 32'(ei), 32'hFFFF_FFFF);

    gen(6'b111111, 6'b000000, 1'b0, 1'b0, 0, 0);
    chk("pin_illegal", 32'({prog.size() == 2, prog[1].exp.illegal}), 32'(2'b11));
    run_prog(ei);

    for (int i = 0; i < NT; i++) begin
      gen(t_op[i], t_fn[i], t_z[i], (i % 2) == 1, i % 3, ((i % 2) == 1) ? 2 : 0);
      run_prog(ei);
    end

    // SW whose data access times out: the fault replaces the write.
    gen(6'b101011, 6'b000000, 1'b0, 1'b0, 0, 6);
    run_prog(ei);
    chk("mem_timeout_cycle", 32'(ei), 32'd7);

    // Reset in the middle of a SW data access.
    gen(6'b101011, 6'b000000, 1'b0, 1'b0, 0, 3);
    while (prog.size() > 4) void'(prog.pop_back());
    run_prog(ei);
    mem_ready = 1'b0;
    #1;
    chk("pre_abort", 32'({state, mem_we}), 32'({3'd3, 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("abort_async", 32'({state, mem_we}), 32'({3'd0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (mem_we) we_seen++;
      @(negedge clk);
    end
    chk("no_write_after_abort", 32'(we_seen), 32'd0);
    do_reset();

    gen(6'b000000, 6'b100000, 1'b0, 1'b1, 0, 0);
    run_prog(ei);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
